// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches ps2c, shifts in
// start/8 data/odd parity/stop, and reports each byte with a done tick and error pulses.
module ps2_rx #(
    parameter int unsigned FILTER_W       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned TMO_W          = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    inout  tri         ps2d,
    inout  tri         ps2c,
    output logic       rx_idle,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       parity_err,
    output logic       frame_err
);

    typedef enum logic [1:0] {StIdle, StDps, StLoad} state_t;

    localparam logic [TMO_W-1:0] TmoReload = TMO_W'(TIMEOUT_CYCLES);

    state_t              state_reg, state_next;
    logic [3:0]          n_reg, n_next;
    logic [10:0]         b_reg, b_next;
    logic [7:0]          dout_reg, dout_next;
    logic [TMO_W-1:0]    tmo_reg, tmo_next;

    logic                ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
    logic [FILTER_W-1:0] filter_reg, filter_next;
    logic                f_ps2c_reg, f_ps2c_next;
    logic                fall_edge;

    // Synchronizers idle high, matching the pulled-up bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2c_s1    <= 1'b1;
            ps2c_s2    <= 1'b1;
            ps2d_s1    <= 1'b1;
            ps2d_s2    <= 1'b1;
            filter_reg <= '0;
            f_ps2c_reg <= 1'b0;
        end else begin
            ps2c_s1    <= ps2c;
            ps2c_s2    <= ps2c_s1;
            ps2d_s1    <= ps2d;
            ps2d_s2    <= ps2d_s1;
            filter_reg <= filter_next;
            f_ps2c_reg <= f_ps2c_next;
        end
    end

    always_comb begin
        filter_next = {ps2c_s2, filter_reg[FILTER_W-1:1]};
        if (&filter_next) begin
            f_ps2c_next = 1'b1;
        end else if (~|filter_next) begin
            f_ps2c_next = 1'b0;
        end else begin
            f_ps2c_next = f_ps2c_reg;
        end
    end

    assign fall_edge = f_ps2c_reg & ~f_ps2c_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= StIdle;
            n_reg     <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            tmo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            tmo_reg   <= tmo_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        dout_next    = dout_reg;
        tmo_next     = tmo_reg;
        rx_idle      = 1'b0;
        rx_done_tick = 1'b0;
        parity_err   = 1'b0;
        frame_err    = 1'b0;
        unique case (state_reg)
            StIdle: begin
                rx_idle = 1'b1;
                // Only a low data line marks a real start bit; anything else is a host RTS
                // pull or noise.
                if (fall_edge && rx_en && !ps2d_s2) begin
                    b_next     = {ps2d_s2, b_reg[10:1]};
                    n_next     = 4'd9;
                    tmo_next   = TmoReload;
                    state_next = StDps;
                end
            end
            StDps: begin
                if (fall_edge) begin
                    b_next   = {ps2d_s2, b_reg[10:1]};
                    tmo_next = TmoReload;
                    if (n_reg == 4'd0) begin
                        dout_next  = b_next[8:1];
                        state_next = StLoad;
                    end else begin
                        n_next = n_reg - 4'd1;
                    end
                end else if (tmo_reg == '0) begin
                    frame_err  = 1'b1;
                    state_next = StIdle;
                end else begin
                    tmo_next = tmo_reg - 1'b1;
                end
            end
            StLoad: begin
                rx_done_tick = 1'b1;
                // The start bit is always 0, so folding it in leaves the odd-parity check
                // over data plus parity unchanged.
                parity_err   = ~(^b_reg[9:0]);
                frame_err    = ~b_reg[10];
                state_next   = StIdle;
            end
            default: state_next = StIdle;
        endcase
    end

    assign dout = dout_reg;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed self-checking bench for ps2_rx: clean, parity-error, stop-error, timeout,
// rejected-start and reset-mid-frame cases.
module tb_ps2_rx;

    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_en = 1'b1;
    logic       ps2c_drv = 1'b1;
    logic       ps2d_drv = 1'b1;
    wire        ps2c;
    wire        ps2d;
    logic       rx_idle, rx_done_tick, parity_err, frame_err;
    logic [7:0] dout;

    assign ps2c = ps2c_drv;
    assign ps2d = ps2d_drv;

    ps2_rx #(
        .FILTER_W       (8),
        .TIMEOUT_CYCLES (1000),
        .TMO_W          (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_en        (rx_en),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .rx_idle      (rx_idle),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor, sampled on the falling edge away from the active edge.
    int         cyc = 0;
    int         tick_cnt = 0;
    int         ferr_alone_cnt = 0;
    int         perr_alone_cnt = 0;
    int         ferr_alone_cyc = 0;
    int         last_fall_cyc = 0;
    logic       tick_perr = 1'b0;
    logic       tick_ferr = 1'b0;
    logic [7:0] tick_dout = 8'h00;
    logic       idle_low_seen = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rx_idle) idle_low_seen <= 1'b1;
        if (rx_done_tick) begin
            tick_cnt  <= tick_cnt + 1;
            tick_perr <= parity_err;
            tick_ferr <= frame_err;
            tick_dout <= dout;
        end else begin
            if (frame_err) begin
                ferr_alone_cnt <= ferr_alone_cnt + 1;
                ferr_alone_cyc <= cyc;
            end
            if (parity_err) perr_alone_cnt <= perr_alone_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic par,
                                          input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    function automatic logic odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Device drives data while ps2c is high; host samples on the falling edge.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2d_drv = bits[i];
            wait_cycles(HALF);
            ps2c_drv = 1'b0;
            last_fall_cyc = cyc;
            wait_cycles(HALF);
            ps2c_drv = 1'b1;
        end
        ps2d_drv = 1'b1;
    endtask

    int t0;
    int dly;

    initial begin
        // Reset state
        wait_cycles(5);
        @(negedge clk);
        check("rst_idle", 32'(rx_idle), 32'd1);
        check("rst_tick", 32'(rx_done_tick), 32'd0);
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_errs", {30'd0, parity_err, frame_err}, 32'd0);
        reset = 1'b0;
        wait_cycles(20);

        // Clean 0xA5
        t0 = tick_cnt;
        idle_low_seen = 1'b0;
        send_bits(frame(8'hA5, odd_par(8'hA5), 1'b1), 11);
        wait_cycles(20);
        check("a5_ticks", 32'(tick_cnt - t0), 32'd1);
        check("a5_dout", 32'(tick_dout), 32'hA5);
        check("a5_errs", {30'd0, tick_perr, tick_ferr}, 32'd0);
        check("a5_idle_low", 32'(idle_low_seen), 32'd1);
        check("a5_idle_after", 32'(rx_idle), 32'd1);

        // 0x3C with wrong parity (correct is 1)
        t0 = tick_cnt;
        send_bits(frame(8'h3C, 1'b0, 1'b1), 11);
        wait_cycles(20);
        check("3c_ticks", 32'(tick_cnt - t0), 32'd1);
        check("3c_perr", 32'(tick_perr), 32'd1);
        check("3c_ferr", 32'(tick_ferr), 32'd0);
        check("3c_dout", 32'(dout), 32'h3C);

        // 0x00 with stop bit 0, then clean 0xFF
        t0 = tick_cnt;
        send_bits(frame(8'h00, 1'b1, 1'b0), 11);
        wait_cycles(20);
        check("00_ticks", 32'(tick_cnt - t0), 32'd1);
        check("00_ferr", 32'(tick_ferr), 32'd1);
        check("00_perr", 32'(tick_perr), 32'd0);
        check("00_dout", 32'(dout), 32'h00);
        t0 = tick_cnt;
        send_bits(frame(8'hFF, 1'b1, 1'b1), 11);
        wait_cycles(20);
        check("ff_ticks", 32'(tick_cnt - t0), 32'd1);
        check("ff_dout", 32'(tick_dout), 32'hFF);
        check("ff_errs", {30'd0, tick_perr, tick_ferr}, 32'd0);

        // Timeout after start + 4 data bits
        t0 = tick_cnt;
        send_bits(frame(8'h96, 1'b1, 1'b1), 5);
        check("tmo_busy", 32'(rx_idle), 32'd0);
        wait_cycles(1100);
        check("tmo_ferr_cnt", 32'(ferr_alone_cnt), 32'd1);
        dly = ferr_alone_cyc - last_fall_cyc;
        check("tmo_delay_win", 32'(dly >= 1000 && dly <= 1030), 32'd1);
        check("tmo_no_tick", 32'(tick_cnt - t0), 32'd0);
        check("tmo_dout_kept", 32'(dout), 32'hFF);
        check("tmo_idle", 32'(rx_idle), 32'd1);
        t0 = tick_cnt;
        send_bits(frame(8'h81, 1'b1, 1'b1), 11);
        wait_cycles(20);
        check("post_tmo_ticks", 32'(tick_cnt - t0), 32'd1);
        check("post_tmo_dout", 32'(tick_dout), 32'h81);
        check("post_tmo_errs", {30'd0, tick_perr, tick_ferr}, 32'd0);

        // Rejected starts: RTS pull with data high, short glitch, rx_en low
        t0 = tick_cnt;
        idle_low_seen = 1'b0;
        ps2d_drv = 1'b1;
        ps2c_drv = 1'b0;
        wait_cycles(100);
        ps2c_drv = 1'b1;
        wait_cycles(30);
        ps2d_drv = 1'b0;
        ps2c_drv = 1'b0;
        wait_cycles(3);
        ps2c_drv = 1'b1;
        wait_cycles(30);
        ps2d_drv = 1'b1;
        rx_en = 1'b0;
        send_bits(frame(8'h42, 1'b1, 1'b1), 11);
        wait_cycles(20);
        check("rej_no_tick", 32'(tick_cnt - t0), 32'd0);
        check("rej_stay_idle", 32'(idle_low_seen), 32'd0);
        check("rej_no_err", 32'(ferr_alone_cnt + perr_alone_cnt), 32'd1);
        rx_en = 1'b1;
        send_bits(frame(8'h42, 1'b1, 1'b1), 11);
        wait_cycles(20);
        check("en_ticks", 32'(tick_cnt - t0), 32'd1);
        check("en_dout", 32'(tick_dout), 32'h42);

        // Reset after 6 bits, then clean 0x5A
        send_bits(frame(8'hC3, 1'b1, 1'b1), 6);
        check("mid_busy", 32'(rx_idle), 32'd0);
        reset = 1'b1;
        wait_cycles(3);
        @(negedge clk);
        check("mr_idle", 32'(rx_idle), 32'd1);
        check("mr_outs", {22'd0, dout, rx_done_tick, parity_err}, 32'd0);
        check("mr_ferr", 32'(frame_err), 32'd0);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(20);
        t0 = tick_cnt;
        send_bits(frame(8'h5A, 1'b1, 1'b1), 11);
        wait_cycles(20);
        check("5a_ticks", 32'(tick_cnt - t0), 32'd1);
        check("5a_dout", 32'(dout), 32'h5A);
        check("5a_errs", {30'd0, tick_perr, tick_ferr}, 32'd0);
        check("stray_errs", 32'(ferr_alone_cnt + perr_alone_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
